alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Issue/writeback controller on the datapath side of the ALU. It accepts one operation request at a time on a valid/ready handshake and drives the ALU operand and opcode inputs from registers. It waits the per-opcode ALU latency, then captures ALU ResultHi/ResultLo into the Z pair, and into the HI/LO registers for MUL/DIV. It presents the captured result on a valid/ready response handshake. MFLO is executed locally from LO without using the ALU.

Parameters:
MUL_LAT, 2, cycles from operand issue to valid ALU MUL result (clocked Booth unit); values 0 or 1 treated as 1
DIV_LAT, 1, cycles from operand issue to valid ALU DIV result; 0 treated as 1
DATA_W, 32, operand/result width

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  5  opcode, ALU encoding (ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010, BR 10011, LOAD 00000, MFLO 11000, SHLA 11111)
req_a  in  DATA_W  operand A
req_b  in  DATA_W  operand B
req_branch  in  1  branch-taken qualifier for BR
alu_ra  out  DATA_W  registered operand A to ALU
alu_rb  out  DATA_W  registered operand B to ALU
alu_op  out  5  registered opcode to ALU
alu_branch  out  1  registered branch qualifier to ALU
alu_hi  in  DATA_W  ALU ResultHi
alu_lo  in  DATA_W  ALU ResultLo
z_hi  out  DATA_W  captured high result
z_lo  out  DATA_W  captured low result
hi_reg  out  DATA_W  HI register (MUL/DIV only)
lo_reg  out  DATA_W  LO register (MUL/DIV only)
rsp_valid  out  1  z_hi/z_lo valid
rsp_ready  in  1  consumer accepts response
illegal  out  1  response opcode not in the legal list; valid only with rsp_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (clear high, async): state IDLE; all DATA_W outputs, alu_op, alu_branch, rsp_valid, illegal and busy set to 0. req_ready is 1 after reset. Clear mid-operation aborts with no capture and no HI/LO update.
- States: IDLE, EXEC, DONE.
- IDLE: req_ready=1.
  - On req_valid & req_ready (cycle T): latch req_a/req_b/req_op/req_branch into alu_* at edge end of T. Load counter with LAT(op): MUL_LAT for MUL, DIV_LAT for DIV, 1 otherwise. Go to EXEC.
- EXEC: req_ready=0, alu_* held stable.
  - Counter decrements each cycle.
  - In the cycle counter==1, sample alu_hi/alu_lo into z_hi/z_lo at that edge. If op is MUL or DIV, also write hi_reg<=alu_hi and lo_reg<=alu_lo. Go to DONE.
- Latency: a 1-cycle op accepted at T has rsp_valid high from T+2. In general, rsp_valid rises at T+1+LAT.
- MFLO: uses the EXEC path with LAT 1, but captures z_lo<=lo_reg and z_hi<=0, ignoring the ALU. HI/LO are unchanged.
- Illegal opcode (any code not in the list): executes as LAT 1, captures z_hi=z_lo=0 regardless of ALU outputs, illegal=1 in DONE. HI/LO are unchanged.
- DONE: rsp_valid=1, req_ready=0.
  - z_* and illegal are held until rsp_valid & rsp_ready, then the sequencer returns to IDLE.
  - There is no same-cycle accept: the next request is accepted no earlier than the cycle after the response handshake.
- req_valid while not in IDLE is ignored (no back-pressure violation; the requester holds the request).
- alu_* keep their last values after completion. z_* keep their last values until the next capture.
- Width: no truncation or extension beyond the ALU outputs. Captured values are bit-exact copies.

Test Plan:
- Reset: assert clear mid-EXEC of MUL -> all outputs 0, req_ready=1 next cycle, hi_reg/lo_reg stay 0.
- ADD: a=5, b=7, rsp_ready=1 -> alu_op=00011 at T+1; rsp_valid at T+2 with z_lo=12, z_hi=0; hi/lo unchanged.
- MUL, MUL_LAT=2: a=0x0001_0000, b=0x0001_0000, ALU model returns product -> rsp_valid at T+3, z_hi=1, z_lo=0, hi_reg=1, lo_reg=0.
- DIV, then MFLO: 17/5 with the ALU model returning lo=3, hi=2 -> hi_reg=2, lo_reg=3. A following MFLO gives z_lo=3, z_hi=0, and alu_op for the MFLO is not used.
- Back-pressure: hold rsp_ready=0 for 5 cycles after an SUB of 3-10 -> rsp_valid held, z_lo=0xFFFF_FFF9 stable, req_ready=0, and a second req_valid is not accepted until the cycle after the handshake.
- Illegal op 10100 -> rsp_valid with illegal=1, z_hi=z_lo=0, HI/LO unchanged; the next legal op completes with illegal=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer: registers one ALU request, waits the per-opcode
// latency, then captures ALU results (and HI/LO for MUL/DIV) for a response handshake.
module alu_op_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_branch,
    output logic [DATA_W-1:0] alu_ra,
    output logic [DATA_W-1:0] alu_rb,
    output logic [4:0]        alu_op,
    output logic              alu_branch,
    input  logic [DATA_W-1:0] alu_hi,
    input  logic [DATA_W-1:0] alu_lo,
    output logic [DATA_W-1:0] z_hi,
    output logic [DATA_W-1:0] z_lo,
    output logic [DATA_W-1:0] hi_reg,
    output logic [DATA_W-1:0] lo_reg,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              illegal,
    output logic              busy
);
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b11000;

    localparam int MUL_L = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int DIV_L = (DIV_LAT < 1) ? 1 : DIV_LAT;
    localparam int MAX_L = (MUL_L > DIV_L) ? MUL_L : DIV_L;
    localparam int CNT_W = (MAX_L < 2) ? 1 : $clog2(MAX_L + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_ra_q, alu_ra_d, alu_rb_q, alu_rb_d;
    logic [4:0]        alu_op_q, alu_op_d;
    logic              alu_branch_q, alu_branch_d;
    logic [DATA_W-1:0] z_hi_q, z_hi_d, z_lo_q, z_lo_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              illegal_q, illegal_d;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
            5'b11000, 5'b11111: op_legal = 1'b1;
            default:            op_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_ra_d     = alu_ra_q;
        alu_rb_d     = alu_rb_q;
        alu_op_d     = alu_op_q;
        alu_branch_d = alu_branch_q;
        z_hi_d       = z_hi_q;
        z_lo_d       = z_lo_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        illegal_d    = illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_ra_d     = req_a;
                    alu_rb_d     = req_b;
                    alu_op_d     = req_op;
                    alu_branch_d = req_branch;
                    if (req_op == OP_MUL)      cnt_d = CNT_W'(MUL_L);
                    else if (req_op == OP_DIV) cnt_d = CNT_W'(DIV_L);
                    else                       cnt_d = CNT_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (!op_legal(alu_op_q)) begin
                        // Unknown opcodes never leak ALU outputs into Z.
                        z_hi_d    = '0;
                        z_lo_d    = '0;
                        illegal_d = 1'b1;
                    end else if (alu_op_q == OP_MFLO) begin
                        z_hi_d    = '0;
                        z_lo_d    = lo_q;
                        illegal_d = 1'b0;
                    end else begin
                        z_hi_d    = alu_hi;
                        z_lo_d    = alu_lo;
                        illegal_d = 1'b0;
                        if (alu_op_q == OP_MUL || alu_op_q == OP_DIV) begin
                            hi_d = alu_hi;
                            lo_d = alu_lo;
                        end
                    end
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_ra_q     <= '0;
            alu_rb_q     <= '0;
            alu_op_q     <= '0;
            alu_branch_q <= 1'b0;
            z_hi_q       <= '0;
            z_lo_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_ra_q     <= alu_ra_d;
            alu_rb_q     <= alu_rb_d;
            alu_op_q     <= alu_op_d;
            alu_branch_q <= alu_branch_d;
            z_hi_q       <= z_hi_d;
            z_lo_q       <= z_lo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            illegal_q    <= illegal_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign illegal    = illegal_q & rsp_valid;
    assign alu_ra     = alu_ra_q;
    assign alu_rb     = alu_rb_q;
    assign alu_op     = alu_op_q;
    assign alu_branch = alu_branch_q;
    assign z_hi       = z_hi_q;
    assign z_lo       = z_lo_q;
    assign hi_reg     = hi_q;
    assign lo_reg     = lo_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a latency-aware ALU model and a response scoreboard.
module tb_alu_op_sequencer;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_BAD  = 5'b10100;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        req_branch = 1'b0;
    logic [31:0] alu_ra, alu_rb;
    logic [4:0]  alu_op;
    logic        alu_branch;
    logic [31:0] alu_hi, alu_lo;
    logic [31:0] z_hi, z_lo, hi_reg, lo_reg;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        illegal, busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] zh, zl, hi, lo;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    alu_op_sequencer #(.MUL_LAT(2), .DIV_LAT(1), .DATA_W(32)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_branch(req_branch),
        .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op), .alu_branch(alu_branch),
        .alu_hi(alu_hi), .alu_lo(alu_lo),
        .z_hi(z_hi), .z_lo(z_lo), .hi_reg(hi_reg), .lo_reg(lo_reg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .illegal(illegal), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic int lat_of(input logic [4:0] op);
        if (op == OP_MUL) return 2;
        return 1;
    endfunction

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return {32'h0, a + b};
            OP_SUB:  return {32'h0, a - b};
            OP_AND:  return {32'h0, a & b};
            OP_MUL:  return {32'h0, a} * {32'h0, b};
            OP_DIV:  return {a % b, a / b};
            default: return {~a, a ^ b ^ 32'hA5A5_0000};
        endcase
    endfunction

    // ALU model: outputs are junk until the opcode's latency has elapsed since issue.
    int age = 0;
    always @(posedge clock) begin
        if (req_valid && req_ready) age <= 1;
        else if (age < 1000)        age <= age + 1;
    end
    assign {alu_hi, alu_lo} = (age >= lat_of(alu_op)) ? alu_fn(alu_op, alu_ra, alu_rb)
                                                        : {32'hDEAD_BEEF, 32'hDEAD_BEEF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic legal(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
            5'b11000, 5'b11111: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    task automatic push_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] r;
        r = alu_fn(op, a, b);
        e.lat = lat_of(op);
        e.ill = 1'b0;
        if (!legal(op)) begin
            e.zh = '0; e.zl = '0; e.ill = 1'b1;
        end else if (op == OP_MFLO) begin
            e.zh = '0; e.zl = m_lo;
        end else begin
            e.zh = r[63:32]; e.zl = r[31:0];
            if (op == OP_MUL || op == OP_DIV) begin
                m_hi = r[63:32]; m_lo = r[31:0];
            end
        end
        e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
    endtask

    // Drives a request in the current cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_branch = 1'b0;
        check("req_ready_before_issue", {63'h0, req_ready}, 64'h1);
        push_exp(op, a, b);
        step();
        req_valid = 1'b0;
        check("alu_op_latched", {59'h0, alu_op}, {59'h0, op});
    endtask

    // Waits for the response, checks latency and contents, then lets the handshake complete.
    task automatic wait_rsp(input string tag);
        exp_t e;
        int n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(1 + e.lat));
        check({tag, "_z_hi"}, {32'h0, z_hi}, {32'h0, e.zh});
        check({tag, "_z_lo"}, {32'h0, z_lo}, {32'h0, e.zl});
        check({tag, "_illegal"}, {63'h0, illegal}, {63'h0, e.ill});
        check({tag, "_hi_reg"}, {32'h0, hi_reg}, {32'h0, e.hi});
        check({tag, "_lo_reg"}, {32'h0, lo_reg}, {32'h0, e.lo});
        rsp_ready = 1'b1;
        step();
        check({tag, "_idle_after"}, {62'h0, req_ready, busy}, 64'h2);
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_outputs", {z_hi, z_lo}, 64'h0);
        check("reset_flags", {59'h0, rsp_valid, illegal, busy, alu_branch, req_ready}, 64'h1);
        step();
        clear = 1'b0;
        step();

        // Clear in the middle of a MUL aborts without capture
        req_valid = 1'b1; req_op = OP_MUL; req_a = 32'h0001_0000; req_b = 32'h0001_0000;
        step();
        req_valid = 1'b0;
        check("mul_in_exec", {63'h0, busy}, 64'h1);
        clear = 1'b1;
        #1;
        check("clear_alu", {27'h0, alu_op, alu_ra}, 64'h0);
        check("clear_hilo", {hi_reg, lo_reg}, 64'h0);
        check("clear_z", {z_hi, z_lo}, 64'h0);
        step();
        clear = 1'b0;
        step();
        check("clear_ready", {61'h0, req_ready, rsp_valid, busy}, 64'h4);
        check("clear_hilo_later", {hi_reg, lo_reg}, 64'h0);

        // ADD
        issue(OP_ADD, 32'd5, 32'd7);
        wait_rsp("add");

        // MUL with two-cycle latency
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_rsp("mul");

        // DIV then MFLO
        issue(OP_DIV, 32'd17, 32'd5);
        wait_rsp("div");
        issue(OP_MFLO, 32'd1, 32'd2);
        wait_rsp("mflo");

        // Back-pressure on a SUB response, with a second request waiting
        rsp_ready = 1'b0;
        issue(OP_SUB, 32'd3, 32'd10);
        begin
            int n = 0;
            while (!rsp_valid && n < 40) begin step(); n++; end
        end
        req_valid = 1'b1; req_op = OP_AND; req_a = 32'hF0F0_1234; req_b = 32'h0FF0_FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", {30'h0, rsp_valid, req_ready, z_lo}, {30'h0, 2'b10, 32'hFFFF_FFF9});
            check("bp_not_accepted", {59'h0, alu_op}, {59'h0, OP_SUB});
        end
        begin
            exp_t e;
            e = sb.pop_front();
            check("bp_sub_z", {z_hi, z_lo}, {e.zh, e.zl});
        end
        rsp_ready = 1'b1;
        step();
        check("bp_no_same_cycle", {58'h0, req_ready, alu_op}, {58'h0, 1'b1, OP_SUB});
        push_exp(OP_AND, req_a, req_b);
        step();
        req_valid = 1'b0;
        check("bp_second_accepted", {59'h0, alu_op}, {59'h0, OP_AND});
        wait_rsp("and");

        // Illegal opcode, then a legal op clears the flag
        issue(OP_BAD, 32'h55, 32'hAA);
        wait_rsp("illegal");
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd2);
        wait_rsp("add_after_illegal");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
